// File: rtl/ifm_bank_loader_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ifm_bank_loader_if                                            |
// | Purpose  : valid/ready stream carrying 128-bit feature-map rows into the |
// |            ifm_bank_loader.                                              |
// | Signals  : s_vld  - stream data valid (source -> loader)                 |
// |            s_data - stream data, DW bits (source -> loader)              |
// |            s_rdy  - stream ready (loader -> source)                      |
// | Modports : master = stream source, slave = loader                        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface ifm_bank_loader_if #(
   parameter int DW = 128
);
   logic          s_vld;
   logic [DW-1:0] s_data;
   logic          s_rdy;

   modport master (output s_vld, output s_data, input s_rdy);
   modport slave  (input s_vld, input s_data, output s_rdy);
endinterface
`default_nettype wire

// File: rtl/ifm_bank_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ifm_bank_loader                                               |
// | Purpose  : write-side controller for the 16-bank 512x128 feature-map     |
// |            BRAM array. Scatters an incoming row stream across the bank   |
// |            write ports (bank-major or interleaved order), then issues a  |
// |            one-cycle start pulse to the layer-00 parser.                 |
// | Ports    : clk, rstn        - clock, async active-low reset              |
// |            iCfg_vld/words/mode - load configuration (IDLE only)          |
// |            iAbort           - abandon the load in progress               |
// |            iParse_busy      - holds oStart off while high                |
// |            s_if (slave)     - input row stream                           |
// |            oEna/oWea/oAddra/oDia - shared BRAM write port               |
// |            oStart, oBusy, oCfg_err, oChksum - status                     |
// | Option   : IFM_BANK_LOADER_CHKSUM_EN enables the running XOR checksum on |
// |            oChksum; otherwise oChksum is tied to zero.                   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module ifm_bank_loader #(
   parameter int DW    = 128,
   parameter int AW    = 9,
   parameter int NBANK = 16
) (
   input  wire logic             clk,
   input  wire logic             rstn,
   input  wire logic             iCfg_vld,
   input  wire logic [9:0]       iCfg_words,
   input  wire logic             iCfg_mode,
   input  wire logic             iAbort,
   input  wire logic             iParse_busy,
   ifm_bank_loader_if.slave      s_if,
   output logic      [NBANK-1:0] oEna,
   output logic      [NBANK-1:0] oWea,
   output logic      [AW-1:0]    oAddra,
   output logic      [DW-1:0]    oDia,
   output logic                  oStart,
   output logic                  oBusy,
   output logic                  oCfg_err,
   output logic      [DW-1:0]    oChksum
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   localparam logic [NBANK-1:0] c_ONE = {{(NBANK-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic [3:0]       bank_q, bank_d;
   logic [AW-1:0]    addr_q, addr_d;
   logic [9:0]       words_q, words_d;
   logic             mode_q, mode_d;
   logic [NBANK-1:0] ena_q, ena_d;
   logic [AW-1:0]    addra_q, addra_d;
   logic [DW-1:0]    dia_q, dia_d;
   logic             cfg_err_q, cfg_err_d;

   logic w_cfg_ok;
   logic w_beat;
   logic w_addr_last;
   logic w_last;
   logic w_cfg_acc;

   assign w_cfg_ok    = (iCfg_words != 10'd0) && (iCfg_words <= 10'd512);
   assign w_beat      = (state_q == S_LOAD) && s_if.s_vld;
   assign w_addr_last = ({1'b0, addr_q} == (words_q - 10'd1));
   // Both orders finish on the same (bank 15, addr words-1) slot.
   assign w_last      = w_beat && (bank_q == 4'hF) && w_addr_last;
   assign w_cfg_acc   = (state_q == S_IDLE) && iCfg_vld && w_cfg_ok;

   always_comb begin
      state_d   = state_q;
      bank_d    = bank_q;
      addr_d    = addr_q;
      words_d   = words_q;
      mode_d    = mode_q;
      ena_d     = '0;
      addra_d   = addra_q;
      dia_d     = dia_q;
      cfg_err_d = 1'b0;
      oStart    = 1'b0;

      // A beat is registered even alongside iAbort, so it still lands.
      if (w_beat) begin
         ena_d   = c_ONE << bank_q;
         addra_d = addr_q;
         dia_d   = s_if.s_data;
         if (!mode_q) begin
            if (w_addr_last) begin
               addr_d = '0;
               bank_d = bank_q + 4'd1;
            end else begin
               addr_d = addr_q + 1'b1;
            end
         end else begin
            bank_d = bank_q + 4'd1;
            if (bank_q == 4'hF) begin
               addr_d = addr_q + 1'b1;
            end
         end
      end

      case (state_q)
         S_IDLE: begin
            if (iCfg_vld) begin
               if (w_cfg_ok) begin
                  words_d = iCfg_words;
                  mode_d  = iCfg_mode;
                  bank_d  = '0;
                  addr_d  = '0;
                  state_d = S_LOAD;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
         end
         S_LOAD: begin
            if (iAbort) begin
               state_d = S_IDLE;
            end else if (w_last) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            // The final strobe occupies the first WAIT cycle; start only after it.
            if (iAbort) begin
               state_d = S_IDLE;
            end else if ((ena_q == '0) && !iParse_busy) begin
               oStart  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= S_IDLE;
         bank_q    <= '0;
         addr_q    <= '0;
         words_q   <= '0;
         mode_q    <= 1'b0;
         ena_q     <= '0;
         addra_q   <= '0;
         dia_q     <= '0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         bank_q    <= bank_d;
         addr_q    <= addr_d;
         words_q   <= words_d;
         mode_q    <= mode_d;
         ena_q     <= ena_d;
         addra_q   <= addra_d;
         dia_q     <= dia_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   assign s_if.s_rdy = (state_q == S_LOAD);
   assign oEna       = ena_q;
   assign oWea       = ena_q;
   assign oAddra     = addra_q;
   assign oDia       = dia_q;
   assign oBusy      = (state_q == S_LOAD) || (state_q == S_WAIT);
   assign oCfg_err   = cfg_err_q;

`ifdef IFM_BANK_LOADER_CHKSUM_EN
   logic [DW-1:0] chk_q, chk_d;

   always_comb begin
      chk_d = chk_q;
      if (w_cfg_acc) begin
         chk_d = '0;
      end else if (w_beat) begin
         chk_d = chk_q ^ s_if.s_data;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         chk_q <= '0;
      end else begin
         chk_q <= chk_d;
      end
   end

   assign oChksum = chk_q;
`else
   assign oChksum = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ifm_bank_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ifm_bank_loader                                            |
// | Purpose  : self-checking bench for ifm_bank_loader: a beat-index model   |
// |            predicts every output each cycle, plus literal expectations.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_ifm_bank_loader;
   localparam int DW = 128;
   localparam int AW = 9;
   localparam int NB = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rstn = 1'b0;
   logic          iCfg_vld = 1'b0;
   logic [9:0]    iCfg_words = '0;
   logic          iCfg_mode = 1'b0;
   logic          iAbort = 1'b0;
   logic          iParse_busy = 1'b0;
   logic [NB-1:0] oEna, oWea;
   logic [AW-1:0] oAddra;
   logic [DW-1:0] oDia, oChksum;
   logic          oStart, oBusy, oCfg_err;

   ifm_bank_loader_if #(.DW(DW)) s_if ();

   ifm_bank_loader #(.DW(DW), .AW(AW), .NBANK(NB)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .iCfg_vld    (iCfg_vld),
      .iCfg_words  (iCfg_words),
      .iCfg_mode   (iCfg_mode),
      .iAbort      (iAbort),
      .iParse_busy (iParse_busy),
      .s_if        (s_if),
      .oEna        (oEna),
      .oWea        (oWea),
      .oAddra      (oAddra),
      .oDia        (oDia),
      .oStart      (oStart),
      .oBusy       (oBusy),
      .oCfg_err    (oCfg_err),
      .oChksum     (oChksum)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- model: phase + beat index -> bank/addr ----------------
   int            m_st = 0;        // 0 idle, 1 loading, 2 waiting for start
   int            m_k = 0;
   int            m_words = 1;
   int            m_waitn = 0;
   logic          m_mode = 1'b0;
   logic [NB-1:0] m_ena = '0;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_dia = '0;
   logic [DW-1:0] m_chk = '0;
   logic          m_err = 1'b0;
   logic          m_beat;
   int            m_b, m_a;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_st = 0; m_k = 0; m_words = 1; m_waitn = 0; m_mode = 1'b0;
         m_ena = '0; m_addr = '0; m_dia = '0; m_chk = '0; m_err = 1'b0;
      end else begin
         m_beat = (m_st == 1) && s_if.s_vld;
         m_err  = (m_st == 0) && iCfg_vld && (iCfg_words == 0 || iCfg_words > 512);
         if (m_beat) begin
            if (!m_mode) begin
               m_b = m_k / m_words; m_a = m_k % m_words;
            end else begin
               m_b = m_k % 16;      m_a = m_k / 16;
            end
            m_ena  = NB'(1) << m_b;
            m_addr = AW'(m_a);
            m_dia  = s_if.s_data;
            m_chk  = m_chk ^ s_if.s_data;
            m_k++;
         end else begin
            m_ena = '0;
         end
         case (m_st)
            0: if (iCfg_vld && iCfg_words != 0 && iCfg_words <= 512) begin
                  m_st = 1; m_k = 0; m_words = int'(iCfg_words);
                  m_mode = iCfg_mode; m_chk = '0;
               end
            1: if (iAbort) m_st = 0;
               else if (m_beat && m_k == 16 * m_words) begin
                  m_st = 2; m_waitn = 0;
               end
            2: if (iAbort) m_st = 0;
               else if (m_waitn >= 1 && !iParse_busy) m_st = 0;
               else m_waitn++;
            default: m_st = 0;
         endcase
      end
   end

   // ---------------- compare + observation log ----------------
   int            cyc = 0;
   int            start_cnt = 0, wr_cnt = 0, err_cnt = 0;
   int            start_cyc = 0, last_acc = 0;
   int            first_bank = -1, first_addr = -1;
   logic          first_pend = 1'b1;
   logic [DW-1:0] chk_at_start = '0;
   logic [DW-1:0] got [16][512];
   logic          exp_start;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rstn) begin
         exp_start = (m_st == 2) && (m_waitn >= 1) && !iParse_busy && !iAbort;
         chk("oS_rdy",   DW'(s_if.s_rdy), DW'(m_st == 1));
         chk("oBusy",    DW'(oBusy),      DW'(m_st != 0));
         chk("oEna",     DW'(oEna),       DW'(m_ena));
         chk("oWea",     DW'(oWea),       DW'(m_ena));
         chk("oAddra",   DW'(oAddra),     DW'(m_addr));
         chk("oDia",     oDia,            m_dia);
         chk("oStart",   DW'(oStart),     DW'(exp_start));
         chk("oCfg_err", DW'(oCfg_err),   DW'(m_err));
`ifdef IFM_BANK_LOADER_CHKSUM_EN
         if (exp_start) chk("oChksum", oChksum, m_chk);
`else
         chk("oChksum", oChksum, '0);
`endif
         if (oEna != '0) begin
            for (int b = 0; b < NB; b++) begin
               if (oEna[b]) begin
                  got[b][oAddra] = oDia;
                  if (first_pend) begin
                     first_bank = b; first_addr = int'(oAddra); first_pend = 1'b0;
                  end
               end
            end
            wr_cnt++;
         end
         if (oStart) begin
            start_cnt++; start_cyc = cyc; chk_at_start = oChksum;
         end
         if (oCfg_err) err_cnt++;
         if (s_if.s_rdy && s_if.s_vld) last_acc = cyc;
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      start_cnt = 0; wr_cnt = 0; err_cnt = 0; first_pend = 1'b1;
   endtask

   task automatic cfg(input int w, input logic m);
      iCfg_vld = 1'b1; iCfg_words = 10'(w); iCfg_mode = m;
      step();
      iCfg_vld = 1'b0;
   endtask

   task automatic send(input int n, input int base, input bit toggle);
      for (int k = 0; k < n; k++) begin
         s_if.s_vld = 1'b1; s_if.s_data = DW'(base + k);
         step();
         if (toggle) begin
            s_if.s_vld = 1'b0;
            step();
         end
      end
      s_if.s_vld = 1'b0;
   endtask

   task automatic wait_start(input int maxc);
      for (int i = 0; i < maxc && start_cnt == 0; i++) step();
      if (start_cnt == 0) chk("start_timeout", DW'(0), DW'(1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1);
   end

   initial begin
      s_if.s_vld = 1'b0; s_if.s_data = '0;
      repeat (3) step();
      chk("rst_busy", DW'(oBusy), DW'(0));
      chk("rst_rdy",  DW'(s_if.s_rdy), DW'(0));
      chk("rst_ena",  DW'(oEna), DW'(0));
      rstn = 1'b1;
      step();

      // bank-major, words=2
      clear_log(); cfg(2, 1'b0); send(32, 0, 1'b0); wait_start(20); repeat (3) step();
      chk("t1_starts", DW'(start_cnt), DW'(1));
      chk("t1_latency", DW'(start_cyc - last_acc), DW'(2));
      chk("t1_writes", DW'(wr_cnt), DW'(32));
      chk("t1_b0a1", got[0][1], DW'(1));
      chk("t1_b1a0", got[1][0], DW'(2));
      chk("t1_b15a1", got[15][1], DW'(31));

      // interleaved, words=2
      clear_log(); cfg(2, 1'b1); send(32, 0, 1'b0); wait_start(20); repeat (3) step();
      chk("t2_starts", DW'(start_cnt), DW'(1));
      chk("t2_b1a1", got[1][1], DW'(17));
      chk("t2_b15a0", got[15][0], DW'(15));
      chk("t2_b0a1", got[0][1], DW'(16));

      // gapped stream, words=1
      clear_log(); cfg(1, 1'b0); send(16, 100, 1'b1);
      chk("t3_rdy_after", DW'(s_if.s_rdy), DW'(0));
      wait_start(20); repeat (3) step();
      chk("t3_writes", DW'(wr_cnt), DW'(16));
      for (int b = 0; b < 16; b++) chk("t3_bank", got[b][0], DW'(100 + b));

      // parser busy holds off start
      clear_log(); iParse_busy = 1'b1; cfg(1, 1'b0); send(16, 0, 1'b0);
      repeat (10) step();
      chk("t4_no_start", DW'(start_cnt), DW'(0));
      chk("t4_busy", DW'(oBusy), DW'(1));
      iParse_busy = 1'b0; step();
      chk("t4_start", DW'(start_cnt), DW'(1));
      repeat (2) step();
      chk("t4_once", DW'(start_cnt), DW'(1));
      chk("t4_idle", DW'(oBusy), DW'(0));

      // illegal configs
      clear_log(); cfg(0, 1'b0); step(); cfg(600, 1'b0); step();
      chk("t5_err", DW'(err_cnt), DW'(2));
      chk("t5_busy", DW'(oBusy), DW'(0));
      chk("t5_rdy", DW'(s_if.s_rdy), DW'(0));

      // abort after beat 5, then fresh load
      clear_log(); cfg(4, 1'b0); send(5, 0, 1'b0);
      iAbort = 1'b1; step(); iAbort = 1'b0; repeat (3) step();
      chk("t6_no_start", DW'(start_cnt), DW'(0));
      chk("t6_writes", DW'(wr_cnt), DW'(5));
      chk("t6_idle", DW'(oBusy), DW'(0));
      clear_log(); cfg(1, 1'b0); send(16, 200, 1'b0); wait_start(20); repeat (2) step();
      chk("t6_first_bank", DW'(first_bank), DW'(0));
      chk("t6_first_addr", DW'(first_addr), DW'(0));
      chk("t6_b0", got[0][0], DW'(200));
      chk("t6_start", DW'(start_cnt), DW'(1));

      // abort coincident with last beat
      clear_log(); cfg(1, 1'b0); send(15, 0, 1'b0);
      s_if.s_vld = 1'b1; s_if.s_data = DW'(15); iAbort = 1'b1; step();
      s_if.s_vld = 1'b0; iAbort = 1'b0; repeat (4) step();
      chk("t7_no_start", DW'(start_cnt), DW'(0));
      chk("t7_writes", DW'(wr_cnt), DW'(16));
      chk("t7_b15", got[15][0], DW'(15));

      // one-hot data for checksum
      clear_log(); cfg(1, 1'b1);
      for (int k = 0; k < 16; k++) begin
         s_if.s_vld = 1'b1; s_if.s_data = DW'(1) << k; step();
      end
      s_if.s_vld = 1'b0;
      wait_start(20); repeat (2) step();
      chk("t8_start", DW'(start_cnt), DW'(1));
`ifdef IFM_BANK_LOADER_CHKSUM_EN
      chk("t8_chksum", chk_at_start, DW'(16'hFFFF));
`else
      chk("t8_chksum", chk_at_start, DW'(0));
`endif

      // asynchronous reset mid-load
      clear_log(); cfg(2, 1'b0);
      s_if.s_vld = 1'b1; s_if.s_data = DW'(7); step(); step();
      #2 rstn = 1'b0;
      #1;
      chk("t9_ena",   DW'(oEna), DW'(0));
      chk("t9_wea",   DW'(oWea), DW'(0));
      chk("t9_addr",  DW'(oAddra), DW'(0));
      chk("t9_dia",   oDia, DW'(0));
      chk("t9_rdy",   DW'(s_if.s_rdy), DW'(0));
      chk("t9_busy",  DW'(oBusy), DW'(0));
      chk("t9_start", DW'(oStart), DW'(0));
      s_if.s_vld = 1'b0;
      step(); rstn = 1'b1; repeat (2) step();
      chk("t9_after", DW'(oBusy), DW'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
